// File: rtl/uart_tx_arb.sv
// Two-requester UART transmit arbiter: per-requester byte FIFOs, round-robin
// grant, and a fixed per-byte gap so the UART core is never overrun.
module uart_tx_arb #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 4400
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       uart_send,
   output logic [7:0] uart_data_in,
   output logic       busy
);

   // state | meaning
   // IDLE  | no byte in flight; pop the granted FIFO when any is non-empty
   // SEND  | uart_send high for this single cycle; load gap counter
   // WAIT  | count down the remainder of the per-byte gap

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   logic [7:0]          mem0_q [DEPTH];
   logic [7:0]          mem1_q [DEPTH];
   logic [1:0][AW-1:0]  wptr_q;
   logic [1:0][AW-1:0]  rptr_q;
   logic [1:0][CW-1:0]  occ_q;
   logic [1:0]          valid;
   logic [1:0]          full;
   logic [1:0]          nempty;
   logic [1:0]          push;
   logic [1:0]          pop;
   logic [7:0]          head0;
   logic [7:0]          head1;

   state_t              state_q, state_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic                send_q, send_d;
   logic [7:0]          data_q, data_d;
   logic                last_q, last_d;
   logic                take;
   logic                sel;

   assign valid      = {req1_valid, req0_valid};
   assign full       = {occ_q[1] == OCC_FULL, occ_q[0] == OCC_FULL};
   assign nempty     = {occ_q[1] != '0, occ_q[0] != '0};
   assign push       = valid & ~full;
   assign req0_ready = ~full[0];
   assign req1_ready = ~full[1];
   assign head0      = mem0_q[rptr_q[0]];
   assign head1      = mem1_q[rptr_q[1]];

   always_ff @(posedge sys_clk) begin
      if (push[0]) mem0_q[wptr_q[0]] <= req0_data;
      if (push[1]) mem1_q[wptr_q[1]] <= req1_data;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
            if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   occ_q[i] <= occ_q[i] + 1'b1;
               2'b01:   occ_q[i] <= occ_q[i] - 1'b1;
               default: occ_q[i] <= occ_q[i];
            endcase
         end
      end
   end

   // On a tie the requester not granted last wins.
   assign sel = (&nempty) ? ~last_q : nempty[1];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         send_q  <= 1'b0;
         data_q  <= 8'h00;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         send_q  <= send_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   // The zero-count edge of WAIT also arbitrates, so under backlog the
   // send strobes land exactly GAP_CYCLES apart instead of GAP_CYCLES+1.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      send_d  = 1'b0;
      data_d  = data_q;
      last_d  = last_q;
      pop     = '0;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: take = 1'b1;
         ST_SEND: begin
            state_d = ST_WAIT;
            gap_d   = GAP_LOAD;
         end
         ST_WAIT: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
               take    = 1'b1;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (take && (|nempty)) begin
         pop[sel] = 1'b1;
         data_d   = sel ? head1 : head0;
         send_d   = 1'b1;
         last_d   = sel;
         state_d  = ST_SEND;
      end
   end

   assign uart_send    = send_q;
   assign uart_data_in = data_q;
   assign busy         = (|nempty) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized checks of uart_tx_arb with a short gap so that
// byte spacing, arbitration order and reset behaviour can be exercised quickly.
module tb_uart_tx_arb;

   localparam int DEPTH = 4;
   localparam int GAP   = 8;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_ready;
   logic       uart_send;
   logic [7:0] uart_data_in;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [7:0] sent_data [$];
   int         sent_cyc [$];

   uart_tx_arb #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .uart_send    (uart_send),
      .uart_data_in (uart_data_in),
      .busy         (busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc++;

   always @(negedge sys_clk) begin
      if (sys_rst_n && uart_send) begin
         sent_data.push_back(uart_data_in);
         sent_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst_n  = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) tick();
      sys_rst_n = 1'b1;
      tick();
      sent_data.delete();
      sent_cyc.delete();
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      ok = !busy;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      #3;
      vectors++; if (uart_send !== 1'b0) begin miscompares++; $display("FAIL reset_send: got %b want 0", uart_send); end
      vectors++; if (uart_data_in !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", uart_data_in); end
      vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready0: got %b want 1", req0_ready); end
      vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready1: got %b want 1", req1_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      do_reset();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      do_reset();
      req0_valid = 1'b1;
      req0_data  = 8'h11;
      tick();
      req0_valid = 1'b0;
      vectors++; if (uart_send !== 1'b0) begin miscompares++; $display("FAIL single_early: send %b want 0", uart_send); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
      tick();
      vectors++; if (uart_send !== 1'b1) begin miscompares++; $display("FAIL single_send: got %b want 1", uart_send); end
      vectors++; if (uart_data_in !== 8'h11) begin miscompares++; $display("FAIL single_data: got %h want 11", uart_data_in); end
      tick();
      vectors++; if (uart_send !== 1'b0) begin miscompares++; $display("FAIL single_pulse: got %b want 0", uart_send); end
      vectors++; if (uart_data_in !== 8'h11) begin miscompares++; $display("FAIL single_hold: got %h want 11", uart_data_in); end
      repeat (GAP - 2) tick();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_gap: got %b want 1", busy); end
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", busy); end
      vectors++; if (sent_data.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", sent_data.size()); end
   endtask

   task automatic test_tie();
      logic [7:0] exp [4];
      bit ok;
      int n;
      exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
      do_reset();
      req0_valid = 1'b1; req0_data = 8'hA0;
      req1_valid = 1'b1; req1_data = 8'hB0;
      tick();
      req0_data = 8'hA1;
      req1_data = 8'hB1;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle(8 * GAP, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL tie_timeout: busy %b want 0", busy); end
      vectors++; if (sent_data.size() !== 4) begin miscompares++; $display("FAIL tie_count: got %0d want 4", sent_data.size()); end
      n = (sent_data.size() < 4) ? sent_data.size() : 4;
      for (int i = 0; i < n; i++) begin
         vectors++; if (sent_data[i] !== exp[i]) begin miscompares++; $display("FAIL tie_order[%0d]: got %h want %h", i, sent_data[i], exp[i]); end
         if (i > 0) begin
            vectors++; if (sent_cyc[i] - sent_cyc[i-1] !== GAP) begin miscompares++; $display("FAIL tie_gap[%0d]: got %0d want %0d", i, sent_cyc[i] - sent_cyc[i-1], GAP); end
         end
      end
   endtask

   task automatic test_full();
      logic [7:0] exp [6];
      int k, n;
      bit acc, ok;
      exp = '{8'h50, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h50;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      k = 0; n = 0;
      req1_valid = 1'b1;
      req1_data  = exp[1];
      while (k < 5 && n < 100) begin
         acc = req1_ready;
         if (k == 4 && acc) begin
            vectors++; if (uart_send !== 1'b1 || uart_data_in !== 8'hC0) begin miscompares++; $display("FAIL full_reopen: send %b data %h want 1 c0", uart_send, uart_data_in); end
         end
         tick();
         n++;
         if (acc) begin
            k++;
            if (k == 4) begin
               vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", req1_ready); end
            end
            if (k < 5) req1_data = exp[k+1];
         end
      end
      req1_valid = 1'b0;
      vectors++; if (k !== 5) begin miscompares++; $display("FAIL full_accept: got %0d want 5", k); end
      wait_idle(10 * GAP, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL full_timeout: busy %b want 0", busy); end
      vectors++; if (sent_data.size() !== 6) begin miscompares++; $display("FAIL full_count: got %0d want 6", sent_data.size()); end
      for (int i = 0; i < 6 && i < sent_data.size(); i++) begin
         vectors++; if (sent_data[i] !== exp[i]) begin miscompares++; $display("FAIL full_order[%0d]: got %h want %h", i, sent_data[i], exp[i]); end
      end
   endtask

   task automatic test_push_pop();
      bit ok;
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h3C;
      tick();
      req0_data = 8'h3D;
      tick();
      req0_valid = 1'b0;
      vectors++; if (uart_send !== 1'b1 || uart_data_in !== 8'h3C) begin miscompares++; $display("FAIL pp_send: send %b data %h want 1 3c", uart_send, uart_data_in); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pp_busy: got %b want 1", busy); end
      wait_idle(4 * GAP, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL pp_timeout: busy %b want 0", busy); end
      vectors++; if (sent_data.size() !== 2) begin miscompares++; $display("FAIL pp_count: got %0d want 2", sent_data.size()); end
      if (sent_data.size() == 2) begin
         vectors++; if (sent_data[1] !== 8'h3D) begin miscompares++; $display("FAIL pp_second: got %h want 3d", sent_data[1]); end
         vectors++; if (sent_cyc[1] - sent_cyc[0] !== GAP) begin miscompares++; $display("FAIL pp_gap: got %0d want %0d", sent_cyc[1] - sent_cyc[0], GAP); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_data = 8'h61 + 8'(i);
         tick();
      end
      req0_valid = 1'b0;
      tick();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
      sys_rst_n = 1'b0;
      #1;
      vectors++; if (uart_send !== 1'b0) begin miscompares++; $display("FAIL mid_send: got %b want 0", uart_send); end
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b%b want 11", req1_ready, req0_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
      vectors++; if (uart_data_in !== 8'h00) begin miscompares++; $display("FAIL mid_data: got %h want 00", uart_data_in); end
      tick();
      sys_rst_n = 1'b1;
      repeat (3 * GAP) tick();
      vectors++; if (sent_data.size() !== 1) begin miscompares++; $display("FAIL mid_leak: got %0d sends want 1", sent_data.size()); end
      req1_valid = 1'b1; req1_data = 8'h77;
      tick();
      req1_valid = 1'b0;
      tick();
      vectors++; if (uart_send !== 1'b1 || uart_data_in !== 8'h77) begin miscompares++; $display("FAIL mid_after: send %b data %h want 1 77", uart_send, uart_data_in); end
      sys_rst_n = 1'b0;
      #1;
      vectors++; if (uart_send !== 1'b0) begin miscompares++; $display("FAIL mid_send_drop: got %b want 0", uart_send); end
      tick();
      sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      localparam int NPORT = 200;
      logic [7:0] exp0 [$];
      logic [7:0] exp1 [$];
      logic [7:0] want;
      int n0, n1, budget;
      bit a0, a1, ok, have;
      do_reset();
      n0 = 0; n1 = 0; budget = 0;
      while ((n0 < NPORT || n1 < NPORT) && budget < 40000) begin
         if (!req0_valid && n0 < NPORT && $urandom_range(0, 1) == 1) begin
            req0_valid = 1'b1;
            req0_data  = {1'b0, 7'($urandom)};
         end
         if (!req1_valid && n1 < NPORT && $urandom_range(0, 1) == 1) begin
            req1_valid = 1'b1;
            req1_data  = {1'b1, 7'($urandom)};
         end
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         tick();
         budget++;
         if (a0) begin exp0.push_back(req0_data); n0++; req0_valid = 1'b0; end
         if (a1) begin exp1.push_back(req1_data); n1++; req1_valid = 1'b0; end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle(4 * DEPTH * GAP, ok);
      vectors++; if (!ok || n0 !== NPORT || n1 !== NPORT) begin miscompares++; $display("FAIL rnd_timeout: busy %b n0 %0d n1 %0d want 0 %0d %0d", busy, n0, n1, NPORT, NPORT); end
      vectors++; if (sent_data.size() !== 2 * NPORT) begin miscompares++; $display("FAIL rnd_count: got %0d want %0d", sent_data.size(), 2 * NPORT); end
      for (int i = 0; i < sent_data.size(); i++) begin
         have = sent_data[i][7] ? (exp1.size() > 0) : (exp0.size() > 0);
         want = 8'h00;
         if (have) want = sent_data[i][7] ? exp1.pop_front() : exp0.pop_front();
         vectors++; if (!have || sent_data[i] !== want) begin miscompares++; $display("FAIL rnd_order[%0d]: got %h want %h", i, sent_data[i], want); end
         if (i > 0) begin
            vectors++; if (sent_cyc[i] - sent_cyc[i-1] < GAP) begin miscompares++; $display("FAIL rnd_gap[%0d]: got %0d want >= %0d", i, sent_cyc[i] - sent_cyc[i-1], GAP); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_full();
      test_push_pop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
